d_cache_data_bank: RTL and testbench

- Parametrised, multi-way data storage bank for the L1 data cache.
- Provides a CPU-side single-word port with byte strobes and 1-cycle synchronous read latency.
- Provides a refill port that writes a whole cache line from the memory side as a valid/ready beat stream, under a small FSM.
- Sits between the D-cache controller (tag/hit logic) and the AXI refill path; holds no tags or valid bits.

---
 rtl/d_cache_data_bank_if.sv | 48 ++++
 rtl/d_cache_data_bank.sv | 147 ++++++++++++++
 tb/tb_d_cache_data_bank.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_data_bank_if.sv
// rtl/d_cache_data_bank_if.sv - CPU and refill port bundle for the D-cache data bank
interface d_cache_data_bank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int WAYS   = 2,
  parameter int BEATS  = 2
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = ADDR_W - BEAT_W;
  localparam int STRB_W = DATA_W / 8;

  // CPU single-word port
  logic              cpu_req_i;
  logic              cpu_ready_o;
  logic [WAY_W-1:0]  cpu_way_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [STRB_W-1:0] cpu_wstrb_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_rvalid_o;

  // Line refill port
  logic              refill_start_i;
  logic [WAY_W-1:0]  refill_way_i;
  logic [LINE_W-1:0] refill_line_i;
  logic              refill_valid_i;
  logic [DATA_W-1:0] refill_data_i;
  logic              refill_ready_o;
  logic              refill_done_o;
  logic              busy_o;

  // Controller / refill-path side
  modport master (
    output cpu_req_i, cpu_way_i, cpu_addr_i, cpu_wdata_i, cpu_wstrb_i,
    input  cpu_ready_o, cpu_rdata_o, cpu_rvalid_o,
    output refill_start_i, refill_way_i, refill_line_i, refill_valid_i, refill_data_i,
    input  refill_ready_o, refill_done_o, busy_o
  );

  // Data bank side
  modport slave (
    input  cpu_req_i, cpu_way_i, cpu_addr_i, cpu_wdata_i, cpu_wstrb_i,
    output cpu_ready_o, cpu_rdata_o, cpu_rvalid_o,
    input  refill_start_i, refill_way_i, refill_line_i, refill_valid_i, refill_data_i,
    output refill_ready_o, refill_done_o, busy_o
  );
endinterface

// File: rtl/d_cache_data_bank.sv
// rtl/d_cache_data_bank.sv - multi-way L1 D-cache data storage with CPU port and line refill FSM
module d_cache_data_bank #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int WAYS   = 2,
  parameter int BEATS  = 2
) (
  input logic               clk,
  input logic               rst,
  d_cache_data_bank_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = ADDR_W - BEAT_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = WAY_W + ADDR_W;

  // With a single way the one way bit is forced to zero so indices stay inside the array.
  localparam logic [WAY_W-1:0]  WAY_MASK  = WAY_W'(WAYS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BEAT_W-1:0] r_beat;
  logic [WAY_W-1:0]  r_fill_way;
  logic [LINE_W-1:0] r_fill_line;

  logic [DATA_W-1:0] r_mem [WAYS*DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic              w_busy;
  logic              w_refill_ready;
  logic              w_refill_done;
  logic              w_cpu_acc;
  logic              w_cpu_we;
  logic              w_cpu_re;
  logic              w_refill_we;
  logic [IDX_W-1:0]  w_cpu_idx;
  logic [IDX_W-1:0]  w_refill_idx;

  // CPU and refill never write together: CPU is only accepted in IDLE, refill beats only in FILL.
  assign w_cpu_acc    = bus.cpu_req_i && (r_state == S_IDLE);
  assign w_cpu_we     = w_cpu_acc && (|bus.cpu_wstrb_i);
  assign w_cpu_re     = w_cpu_acc && !(|bus.cpu_wstrb_i);
  assign w_refill_we  = (r_state == S_FILL) && bus.refill_valid_i;
  assign w_cpu_idx    = {bus.cpu_way_i & WAY_MASK, bus.cpu_addr_i};
  assign w_refill_idx = {r_fill_way & WAY_MASK, r_fill_line, r_beat};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: a started refill runs BEATS accepted beats, then one DONE cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.refill_start_i) w_state_nxt = S_FILL;
      S_FILL:  if (bus.refill_valid_i && (r_beat == LAST_BEAT)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from state only
  always_comb begin
    w_busy         = 1'b0;
    w_refill_ready = 1'b0;
    w_refill_done  = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_busy         = 1'b1;
        w_refill_ready = 1'b1;
      end
      S_DONE: begin
        w_busy        = 1'b1;
        w_refill_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Refill target latch and beat counter; the counter wraps to 0 on the last beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat      <= '0;
      r_fill_way  <= '0;
      r_fill_line <= '0;
    end else if ((r_state == S_IDLE) && bus.refill_start_i) begin
      r_beat      <= '0;
      r_fill_way  <= bus.refill_way_i;
      r_fill_line <= bus.refill_line_i;
    end else if (w_refill_we) begin
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

  // Storage writes; no reset clear, and nothing is written while reset is held
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_refill_we) begin
        r_mem[w_refill_idx] <= bus.refill_data_i;
      end else if (w_cpu_we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (bus.cpu_wstrb_i[i]) begin
            r_mem[w_cpu_idx][i*8 +: 8] <= bus.cpu_wdata_i[i*8 +: 8];
          end
        end
      end
    end
  end

  // Registered CPU read: data captured on accept, held until the next accepted read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_cpu_re;
      if (w_cpu_re) begin
        r_rdata <= r_mem[w_cpu_idx];
      end
    end
  end

  assign bus.cpu_ready_o    = !w_busy;
  assign bus.cpu_rdata_o    = r_rdata;
  assign bus.cpu_rvalid_o   = r_rvalid;
  assign bus.refill_ready_o = w_refill_ready;
  assign bus.refill_done_o  = w_refill_done;
  assign bus.busy_o         = w_busy;
endmodule

// File: tb/tb_d_cache_data_bank.sv
// tb/tb_d_cache_data_bank.sv - self-checking bench for d_cache_data_bank
module tb_d_cache_data_bank;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 6;
  localparam int WAYS   = 2;
  localparam int BEATS  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  d_cache_data_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAYS(WAYS), .BEATS(BEATS)) bus ();

  d_cache_data_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAYS(WAYS), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] byte_mask(input bit [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Behavioural model: word array with per-byte "known" flags, plus refill progress.
  bit [63:0] m_mem   [WAYS][64];
  bit [7:0]  m_known [WAYS][64];
  bit        m_active = 1'b0;
  bit        m_done   = 1'b0;
  int        m_beats  = 0;
  int        m_way    = 0;
  int        m_line   = 0;
  bit        m_rvalid = 1'b0;
  bit [63:0] m_rdata  = 64'h0;
  bit [7:0]  m_rknown = 8'hFF;

  always @(posedge clk or negedge rst) begin
    bit idle;
    int a;
    int w;
    if (!rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_beats  = 0;
      m_rvalid = 1'b0;
      m_rdata  = 64'h0;
      m_rknown = 8'hFF;
    end else begin
      idle     = !(m_active || m_done);
      m_rvalid = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_active && bus.refill_valid_i) begin
        a = m_line * BEATS + m_beats;
        m_mem[m_way][a]   = bus.refill_data_i;
        m_known[m_way][a] = 8'hFF;
        m_beats++;
        if (m_beats == BEATS) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_beats  = 0;
        end
      end
      if (idle && bus.cpu_req_i) begin
        w = int'(bus.cpu_way_i);
        a = int'(bus.cpu_addr_i);
        if (bus.cpu_wstrb_i != 8'h00) begin
          for (int i = 0; i < 8; i++) begin
            if (bus.cpu_wstrb_i[i]) begin
              m_mem[w][a][i*8 +: 8] = bus.cpu_wdata_i[i*8 +: 8];
              m_known[w][a][i]      = 1'b1;
            end
          end
        end else begin
          m_rvalid = 1'b1;
          m_rdata  = m_mem[w][a];
          m_rknown = m_known[w][a];
        end
      end
      if (idle && bus.refill_start_i) begin
        m_active = 1'b1;
        m_beats  = 0;
        m_way    = int'(bus.refill_way_i);
        m_line   = int'(bus.refill_line_i);
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    chk("m_cpu_ready",    bus.cpu_ready_o,    !(m_active || m_done));
    chk("m_busy",         bus.busy_o,         m_active || m_done);
    chk("m_refill_ready", bus.refill_ready_o, m_active);
    chk("m_refill_done",  bus.refill_done_o,  m_done);
    chk("m_rvalid",       bus.cpu_rvalid_o,   m_rvalid);
    chk("m_rdata",        bus.cpu_rdata_o & byte_mask(m_rknown), m_rdata & byte_mask(m_rknown));
  end

  task automatic cpu_op(input int way, input int addr, input logic [63:0] wd, input logic [7:0] ws);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_way_i   = 1'(way);
    bus.cpu_addr_i  = 6'(addr);
    bus.cpu_wdata_i = wd;
    bus.cpu_wstrb_i = ws;
    @(negedge clk);
    bus.cpu_req_i   = 1'b0;
    bus.cpu_wstrb_i = 8'h00;
  endtask

  task automatic cpu_read_chk(input string name, input int way, input int addr, input logic [63:0] exp);
    cpu_op(way, addr, 64'h0, 8'h00);
    chk({name, "_rvalid"}, bus.cpu_rvalid_o, 1'b1);
    chk(name, bus.cpu_rdata_o, exp);
  endtask

  // Two-beat refill with a one-cycle valid gap; counts done pulses seen afterwards
  task automatic refill(input int way, input int line, input logic [63:0] b0, input logic [63:0] b1,
                        output int dones);
    bus.refill_start_i = 1'b1;
    bus.refill_way_i   = 1'(way);
    bus.refill_line_i  = 5'(line);
    @(negedge clk);
    bus.refill_start_i = 1'b0;
    bus.refill_valid_i = 1'b1;
    bus.refill_data_i  = b0;
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    @(negedge clk);
    bus.refill_valid_i = 1'b1;
    bus.refill_data_i  = b1;
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.refill_done_o) dones++;
      @(negedge clk);
    end
  endtask

  initial begin
    int dones;
    logic [63:0] v;
    bus.cpu_req_i = 1'b0; bus.cpu_way_i = '0; bus.cpu_addr_i = '0;
    bus.cpu_wdata_i = '0; bus.cpu_wstrb_i = '0;
    bus.refill_start_i = 1'b0; bus.refill_way_i = '0; bus.refill_line_i = '0;
    bus.refill_valid_i = 1'b0; bus.refill_data_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready",    bus.cpu_ready_o,    1'b1);
    chk("rst_busy",         bus.busy_o,         1'b0);
    chk("rst_refill_ready", bus.refill_ready_o, 1'b0);
    chk("rst_refill_done",  bus.refill_done_o,  1'b0);
    chk("rst_rvalid",       bus.cpu_rvalid_o,   1'b0);
    chk("rst_rdata",        bus.cpu_rdata_o,    64'h0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Read latency and single-cycle rvalid
    cpu_op(0, 5, 64'h0, 8'h00);
    chk("t1_rvalid",       bus.cpu_rvalid_o,   1'b1);
    chk("t1_cpu_ready",    bus.cpu_ready_o,    1'b1);
    chk("t1_refill_ready", bus.refill_ready_o, 1'b0);
    chk("t1_refill_done",  bus.refill_done_o,  1'b0);
    @(negedge clk);
    chk("t1_rvalid_pulse", bus.cpu_rvalid_o,   1'b0);

    // Byte-strobe merge
    cpu_op(1, 3, 64'h1122334455667788, 8'hFF);
    cpu_op(1, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    cpu_read_chk("t2_merge", 1, 3, 64'h11223344AAAAAAAA);

    // Refill way1 line2 with a valid gap; neighbouring way untouched
    cpu_op(0, 4, 64'h0404040404040404, 8'hFF);
    refill(1, 2, 64'hDEAD, 64'hBEEF, dones);
    chk("t3_done_count", 32'(dones), 32'd1);
    chk("t3_idle_after", bus.busy_o, 1'b0);
    cpu_read_chk("t3_w1a4", 1, 4, 64'hDEAD);
    cpu_read_chk("t3_w1a5", 1, 5, 64'hBEEF);
    cpu_read_chk("t3_w0a4", 0, 4, 64'h0404040404040404);

    // CPU read held during FILL is ignored, then accepted after DONE
    bus.refill_start_i = 1'b1; bus.refill_way_i = 1'b0; bus.refill_line_i = 5'd5;
    @(negedge clk);
    bus.refill_start_i = 1'b0;
    chk("t4_ready_fill", bus.cpu_ready_o, 1'b0);
    bus.cpu_req_i = 1'b1; bus.cpu_way_i = 1'b1; bus.cpu_addr_i = 6'd4; bus.cpu_wstrb_i = 8'h00;
    bus.refill_valid_i = 1'b1; bus.refill_data_i = 64'h1010;
    @(negedge clk);
    chk("t4_no_rvalid", bus.cpu_rvalid_o, 1'b0);
    bus.refill_data_i = 64'h1111;
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    chk("t4_done",         bus.refill_done_o, 1'b1);
    chk("t4_no_rvalid2",   bus.cpu_rvalid_o,  1'b0);
    @(negedge clk);
    chk("t4_ready_again",  bus.cpu_ready_o,   1'b1);
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    chk("t4_reissue_rvalid", bus.cpu_rvalid_o, 1'b1);
    chk("t4_reissue_rdata",  bus.cpu_rdata_o,  64'hDEAD);
    cpu_read_chk("t4_w0a10", 0, 10, 64'h1010);
    cpu_read_chk("t4_w0a11", 0, 11, 64'h1111);

    // Reset after the first beat, then a fresh refill of the same line
    bus.refill_start_i = 1'b1; bus.refill_way_i = 1'b0; bus.refill_line_i = 5'd6;
    @(negedge clk);
    bus.refill_start_i = 1'b0;
    bus.refill_valid_i = 1'b1; bus.refill_data_i = 64'h6060;
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5_busy",         bus.busy_o,         1'b0);
    chk("t5_cpu_ready",    bus.cpu_ready_o,    1'b1);
    chk("t5_refill_ready", bus.refill_ready_o, 1'b0);
    chk("t5_refill_done",  bus.refill_done_o,  1'b0);
    chk("t5_rdata",        bus.cpu_rdata_o,    64'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    cpu_read_chk("t5_kept_beat", 0, 12, 64'h6060);
    refill(0, 6, 64'hC0DE0, 64'hC0DE1, dones);
    chk("t5_done_count", 32'(dones), 32'd1);
    cpu_read_chk("t5_w0a12", 0, 12, 64'hC0DE0);
    cpu_read_chk("t5_w0a13", 0, 13, 64'hC0DE1);

    // CPU write alongside start in IDLE; second start during FILL ignored
    cpu_op(1, 14, 64'h1414141414141414, 8'hFF);
    cpu_op(1, 15, 64'h1515151515151515, 8'hFF);
    bus.refill_start_i = 1'b1; bus.refill_way_i = 1'b0; bus.refill_line_i = 5'd8;
    bus.cpu_req_i = 1'b1; bus.cpu_way_i = 1'b1; bus.cpu_addr_i = 6'd20;
    bus.cpu_wdata_i = 64'h2020202020202020; bus.cpu_wstrb_i = 8'hFF;
    @(negedge clk);
    bus.cpu_req_i = 1'b0; bus.cpu_wstrb_i = 8'h00;
    bus.refill_way_i = 1'b1; bus.refill_line_i = 5'd7;
    bus.refill_valid_i = 1'b1; bus.refill_data_i = 64'h8080;
    @(negedge clk);
    bus.refill_start_i = 1'b0;
    bus.refill_data_i = 64'h8181;
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    chk("t6_done", bus.refill_done_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_idle", bus.busy_o, 1'b0);
    cpu_read_chk("t6_cpu_write", 1, 20, 64'h2020202020202020);
    cpu_read_chk("t6_w0a16",     0, 16, 64'h8080);
    cpu_read_chk("t6_w0a17",     0, 17, 64'h8181);
    cpu_read_chk("t6_w1a14",     1, 14, 64'h1414141414141414);
    cpu_read_chk("t6_w1a15",     1, 15, 64'h1515151515151515);

    // Make every word known, then random traffic checked by the model
    for (int w = 0; w < WAYS; w++) begin
      for (int a = 0; a < 64; a++) begin
        v = {$urandom, $urandom};
        cpu_op(w, a, v, 8'hFF);
      end
    end
    for (int n = 0; n < 800; n++) begin
      bus.cpu_req_i      = 1'($urandom_range(0, 1));
      bus.cpu_way_i      = 1'($urandom_range(0, 1));
      bus.cpu_addr_i     = 6'($urandom_range(0, 63));
      bus.cpu_wdata_i    = {$urandom, $urandom};
      bus.cpu_wstrb_i    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      bus.refill_start_i = ($urandom_range(0, 7) == 0);
      bus.refill_way_i   = 1'($urandom_range(0, 1));
      bus.refill_line_i  = 5'($urandom_range(0, 31));
      bus.refill_valid_i = ($urandom_range(0, 2) != 0);
      bus.refill_data_i  = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.cpu_req_i = 1'b0; bus.refill_start_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bus.refill_valid_i = 1'b1;
      bus.refill_data_i  = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.refill_valid_i = 1'b0;
    for (int a = 0; a < 64; a++) begin
      cpu_op(a % 2, a, 64'h0, 8'h00);
    end
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
